game_ctrl: RTL and testbench

Game-control stage directly downstream of the bird position register. Each frame it compares the bird's bounding box against the screen limits and the current pipe, keeps score, and runs the IDLE/PLAY/DEAD game state machine. It drives the bird register's reset, so the bird is parked at its start position whenever no game is running.

---
 rtl/game_ctrl.sv | 132 +++++++++++++
 tb/tb_game_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: per-frame collision check, scoring and IDLE/PLAY/DEAD FSM.
// In: clk, reset, frame_tick, start, bird/pipe/gap coords. Out: bird_reset, playing, game_over, score.
module game_ctrl #(
  parameter int N           = 10,
  parameter int BIRD_SIZE   = 15,
  parameter int CEIL_Y      = 0,
  parameter int FLOOR_Y     = 479,
  parameter int DEAD_FRAMES = 60,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [N-1:0]       bird_x,
  input  logic [N-1:0]       bird_y0,
  input  logic [N-1:0]       bird_y1,
  input  logic [N-1:0]       pipe_x0,
  input  logic [N-1:0]       pipe_x1,
  input  logic [N-1:0]       gap_y0,
  input  logic [N-1:0]       gap_y1,
  output logic               bird_reset,
  output logic               playing,
  output logic               game_over,
  output logic [SCORE_W-1:0] score
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  localparam int DW = $clog2(DEAD_FRAMES + 1);

  localparam logic [N-1:0] CEIL  = CEIL_Y[N-1:0];
  localparam logic [N-1:0] FLOOR = FLOOR_Y[N-1:0];
  localparam logic [N:0]   BW_M1 = (N+1)'(BIRD_SIZE - 1);
  localparam logic [DW-1:0] DLAST = DW'(DEAD_FRAMES - 1);

  logic [1:0]         state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               passed_q, passed_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic               start_q, start_d;

  logic start_rise;
  logic hit_screen;
  logic overlap_x;
  logic hit_pipe;
  logic hit;
  logic [N:0] bird_x1;

  assign start_rise = start & ~start_q;

  // y0 > y1 catches y0 wrapping below zero while moving up.
  assign hit_screen = (bird_y0 <= CEIL) | (bird_y1 >= FLOOR) |
                      (bird_y0 > bird_y1);

  // Right edge kept one bit wider so it cannot wrap near the screen edge.
  assign bird_x1   = {1'b0, bird_x} + BW_M1;
  assign overlap_x = ({1'b0, bird_x} <= {1'b0, pipe_x1}) &
                     (bird_x1 >= {1'b0, pipe_x0});
  assign hit_pipe  = overlap_x &
                     ((bird_y0 < gap_y0) | (bird_y1 > gap_y1));
  assign hit       = hit_screen | hit_pipe;

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    passed_d = passed_q;
    dcnt_d   = dcnt_q;
    start_d  = start;
    unique case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d  = S_PLAY;
          score_d  = '0;
          passed_d = 1'b0;
          dcnt_d   = '0;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          if (hit) begin
            state_d = S_DEAD;
            dcnt_d  = '0;
          end else if (pipe_x1 < bird_x) begin
            if (!passed_q) begin
              passed_d = 1'b1;
              if (score_q != '1)
                score_d = score_q + SCORE_W'(1);
            end
          end else begin
            passed_d = 1'b0;
          end
        end
      end
      S_DEAD: begin
        if (frame_tick) begin
          if (dcnt_q == DLAST) begin
            state_d = S_IDLE;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      score_q  <= '0;
      passed_q <= 1'b0;
      dcnt_q   <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      passed_q <= passed_d;
      dcnt_q   <= dcnt_d;
      start_q  <= start_d;
    end
  end

  assign bird_reset = (state_q == S_IDLE);
  assign playing    = (state_q == S_PLAY);
  assign game_over  = (state_q == S_DEAD);
  assign score      = score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed self-checking bench for game_ctrl.
// Drives reset/start/frame_tick and coordinates; checks FSM and score.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic [9:0] bird_x, bird_y0, bird_y1;
  logic [9:0] pipe_x0, pipe_x1, gap_y0, gap_y1;
  logic       bird_reset, playing, game_over;
  logic [7:0] score;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .bird_x     (bird_x),
    .bird_y0    (bird_y0),
    .bird_y1    (bird_y1),
    .pipe_x0    (pipe_x0),
    .pipe_x1    (pipe_x1),
    .gap_y0     (gap_y0),
    .gap_y1     (gap_y1),
    .bird_reset (bird_reset),
    .playing    (playing),
    .game_over  (game_over),
    .score      (score)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int br, input int pl,
                        input int go, input int sc);
    chk({tag, ".bird_reset"}, int'(bird_reset), br);
    chk({tag, ".playing"}, int'(playing), pl);
    chk({tag, ".game_over"}, int'(game_over), go);
    chk({tag, ".score"}, int'(score), sc);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic safe_pos();
    bird_x  = 10'd160;
    bird_y0 = 10'd240;
    bird_y1 = 10'd254;
    pipe_x0 = 10'd580;
    pipe_x1 = 10'd600;
    gap_y0  = 10'd200;
    gap_y1  = 10'd300;
  endtask

  task automatic set_pipe(input int x1);
    pipe_x1 = 10'(x1);
    pipe_x0 = 10'(x1 - 20);
  endtask

  task automatic press_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk_st("async_reset", 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    start      = 1'b0;
    safe_pos();
    cyc();
    chk_st("reset", 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    cyc();
    chk_st("idle_wait", 1, 0, 0, 0);
    tick();
    chk_st("idle_tick", 1, 0, 0, 0);

    // start rise: PLAY one edge later
    start = 1'b1;
    cyc();
    chk_st("start_rise", 0, 1, 0, 0);
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    chk_st("start_in_play", 0, 1, 0, 0);
    start = 1'b0;
    cyc();

    // pipe pass 170 -> 150, score once
    set_pipe(170); tick(); chk("pass170", int'(score), 0);
    set_pipe(165); tick(); chk("pass165", int'(score), 0);
    set_pipe(160); tick(); chk("pass160", int'(score), 0);
    set_pipe(155); tick(); chk("pass155", int'(score), 1);
    set_pipe(150); tick(); chk("pass150", int'(score), 1);
    cyc();
    chk("no_tick_hold", int'(score), 1);
    set_pipe(600); tick(); chk("wrap600", int'(score), 1);
    set_pipe(150); tick(); chk("pass2", int'(score), 2);
    chk_st("play_after_pass", 0, 1, 0, 2);

    // async reset mid-PLAY
    do_reset();
    chk_st("post_reset", 1, 0, 0, 0);

    // floor hit and dead timeout
    safe_pos();
    press_start();
    chk_st("restart", 0, 1, 0, 0);
    bird_y1 = 10'd479;
    bird_y0 = 10'd465;
    tick();
    chk_st("floor_hit", 0, 0, 1, 0);
    safe_pos();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk_st("start_in_dead", 0, 0, 1, 0);
    for (int i = 0; i < 59; i++) tick();
    chk_st("dead_59", 0, 0, 1, 0);
    tick();
    chk_st("dead_60", 1, 0, 0, 0);

    // near-floor, no hit
    press_start();
    bird_y1 = 10'd478;
    bird_y0 = 10'd464;
    tick();
    chk_st("floor_miss", 0, 1, 0, 0);

    // ceiling
    bird_y0 = 10'd0;
    bird_y1 = 10'd14;
    tick();
    chk_st("ceil_hit", 0, 0, 1, 0);
    do_reset();

    // underflow wrap of y0
    safe_pos();
    press_start();
    bird_y0 = 10'd1020;
    bird_y1 = 10'd10;
    tick();
    chk_st("underflow", 0, 0, 1, 0);
    do_reset();

    // pipe hit after one pass
    safe_pos();
    press_start();
    set_pipe(150);
    tick();
    chk("pre_hit_pass", int'(score), 1);
    pipe_x0 = 10'd165;
    pipe_x1 = 10'd185;
    bird_y0 = 10'd190;
    bird_y1 = 10'd204;
    tick();
    chk_st("pipe_hit", 0, 0, 1, 1);
    do_reset();

    // bird fits inside gap while overlapping: no hit
    safe_pos();
    press_start();
    pipe_x0 = 10'd165;
    pipe_x1 = 10'd185;
    bird_y0 = 10'd200;
    bird_y1 = 10'd300;
    tick();
    chk_st("gap_edge_ok", 0, 1, 0, 0);

    // pass and hit together: no increment
    safe_pos();
    tick();
    set_pipe(150);
    bird_y1 = 10'd479;
    tick();
    chk_st("pass_and_hit", 0, 0, 1, 0);
    do_reset();

    // saturation at 255
    safe_pos();
    press_start();
    for (int i = 0; i < 255; i++) begin
      set_pipe(600); tick();
      set_pipe(150); tick();
    end
    chk("score255", int'(score), 255);
    set_pipe(600); tick();
    set_pipe(150); tick();
    chk_st("saturate", 0, 1, 0, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
